// File: rtl/al4s3b_wb_pkg.sv
// al4s3b_wb_pkg: shared types and constants for the AL4S3B Wishbone initiator
package al4s3b_wb_pkg;
  localparam int AL4S3B_WB_ADDRWIDTH = 17;
  localparam int AL4S3B_WB_DATAWIDTH = 32;
  localparam logic [31:0] AL4S3B_BAD_ACCESS_VALUE = 32'hBAD_FAB_AC;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;
endpackage

// File: rtl/al4s3b_wb_timeout_cntr.sv
// al4s3b_wb_timeout_cntr: ACK-wait counter; expired_o flags the edge on which the count reaches CYCLES
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : restart the count at zero
//   enable_i   : count this cycle (bus cycle without ACK)
//   expired_o  : this enabled cycle brings the count to CYCLES
module al4s3b_wb_timeout_cntr #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  logic [WIDTH-1:0] cnt_q;
  // Looking one increment ahead lets the bus drop after exactly CYCLES cycles of CYC.
  assign expired_o = enable_i && (cnt_q == WIDTH'(CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst || clear_i) cnt_q <= '0;
    else if (enable_i) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/al4s3b_wb_initiator.sv
// al4s3b_wb_initiator: turns single register commands into Wishbone cycles with ACK timeout
//   WB_CLK, WB_RST            : clock, synchronous active-high reset
//   cmd_*                     : command valid/ready handshake with we, adr, byte strobes, write data
//   rsp_*                     : response valid/ready handshake with read data and timeout error
//   WBs_*                     : Wishbone bus toward the fabric IP slave interface
module al4s3b_wb_initiator
  import al4s3b_wb_pkg::*;
#(
  parameter int ADDRWIDTH = AL4S3B_WB_ADDRWIDTH,
  parameter int DATAWIDTH = AL4S3B_WB_DATAWIDTH,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATAWIDTH-1:0] TIMEOUT_READ_VALUE = AL4S3B_BAD_ACCESS_VALUE
) (
  input  logic                   WB_CLK,
  input  logic                   WB_RST,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [ADDRWIDTH-1:0]   cmd_adr,
  input  logic [DATAWIDTH/8-1:0] cmd_byte_stb,
  input  logic [DATAWIDTH-1:0]   cmd_wr_dat,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATAWIDTH-1:0]   rsp_rd_dat,
  output logic                   rsp_err,
  output logic [ADDRWIDTH-1:0]   WBs_ADR,
  output logic                   WBs_CYC,
  output logic [DATAWIDTH/8-1:0] WBs_BYTE_STB,
  output logic                   WBs_WE,
  output logic                   WBs_RD,
  output logic                   WBs_STB,
  output logic [DATAWIDTH-1:0]   WBs_WR_DAT,
  input  logic [DATAWIDTH-1:0]   WBs_RD_DAT,
  input  logic                   WBs_ACK
);
  wb_state_e state_q, state_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic cyc_q, cyc_d, we_q, we_d, rd_q, rd_d;
  logic [ADDRWIDTH-1:0] adr_q, adr_d;
  logic [DATAWIDTH/8-1:0] stb_q, stb_d;
  logic [DATAWIDTH-1:0] wr_dat_q, wr_dat_d, rd_dat_q, rd_dat_d;
  logic accept, expired;
  assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  al4s3b_wb_timeout_cntr #(
    .WIDTH (TIMEOUT_WIDTH),
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (WB_CLK),
    .rst      (WB_RST),
    .clear_i  (accept),
    .enable_i ((state_q == BUS) && !WBs_ACK),
    .expired_o(expired)
  );
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rd_dat_d    = rd_dat_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    rd_d        = rd_q;
    adr_d       = adr_q;
    stb_d       = stb_q;
    wr_dat_d    = wr_dat_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d     = BUS;
        cmd_ready_d = 1'b0;
        cyc_d       = 1'b1;
        we_d        = cmd_we;
        rd_d        = !cmd_we;
        adr_d       = cmd_adr;
        stb_d       = cmd_byte_stb;
        wr_dat_d    = cmd_wr_dat;
      end
      // ACK takes priority over a timeout expiring on the same edge.
      BUS: if (WBs_ACK || expired) begin
        state_d     = RESP;
        cyc_d       = 1'b0;
        we_d        = 1'b0;
        rd_d        = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = !WBs_ACK;
        rd_dat_d    = !WBs_ACK ? TIMEOUT_READ_VALUE : we_q ? '0 : WBs_RD_DAT;
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rd_dat_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_dat_q    <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      adr_q       <= '0;
      stb_q       <= '0;
      wr_dat_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_dat_q    <= rd_dat_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      adr_q       <= adr_d;
      stb_q       <= stb_d;
      wr_dat_q    <= wr_dat_d;
    end
  end
  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rd_dat   = rd_dat_q;
  assign WBs_CYC      = cyc_q;
  assign WBs_STB      = cyc_q;
  assign WBs_WE       = we_q;
  assign WBs_RD       = rd_q;
  assign WBs_ADR      = adr_q;
  assign WBs_BYTE_STB = stb_q;
  assign WBs_WR_DAT   = wr_dat_q;
endmodule
